// File: rtl/rr_grant_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant_scheduler
//  Description : Eight-way round-robin scheduler for one shared resource.
//                It drives a registered one-hot grant and the encoded index of
//                that grant. An optional hold limit (MAX_HOLD) preempts a
//                requester that holds the grant too long.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_scheduler #(
  parameter int MAX_HOLD = 8  // 0 disables preemption; legal range 0..255
) (
  input  logic       clk,
  input  logic       clear,     // asynchronous, active-low
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  // Hold count at which a still-requesting owner is preempted. The owner then
  // keeps the grant for exactly MAX_HOLD cycles.
  localparam logic       C_PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [7:0] C_HOLD_LAST  = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
  localparam logic [7:0] C_HOLD_SAT   = 8'd255;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state,    w_state_nxt;
  logic [2:0] r_ptr,      w_ptr_nxt;
  logic [7:0] r_hold_cnt, w_hold_nxt;
  logic [7:0] r_gnt,      w_gnt_nxt;
  logic [2:0] r_gnt_idx,  w_idx_nxt;
  logic       r_preempt,  w_preempt_nxt;

  // Arbiter signals
  logic [2:0]  w_start;
  logic [15:0] w_req2;
  logic [7:0]  w_rot;
  logic        w_found;
  logic [2:0]  w_off;
  logic [2:0]  w_win;

  // Grant-end conditions
  logic        w_cur_req;
  logic        w_release;
  logic        w_timeout;

  // Search start: the stored pointer while idle. At the end of a grant, the
  // slot after the current owner. This makes the preempted owner the last
  // candidate.
  always_comb begin
    w_start = (r_state == ST_GRANT) ? (r_gnt_idx + 3'd1) : r_ptr;
  end

  // Rotate the request vector so the search start sits at bit 0, then take
  // the lowest set bit and map it back to an absolute index (mod 8).
  always_comb begin
    w_req2  = {req, req};
    w_rot   = w_req2[w_start +: 8];
    w_found = 1'b0;
    w_off   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = 3'(k);
      end
    end
    w_win = w_start + w_off;
  end

  // Release and timeout tests for the current owner
  always_comb begin
    w_cur_req = req[r_gnt_idx];
    w_release = ~w_cur_req;
    w_timeout = C_PREEMPT_EN && w_cur_req && (r_hold_cnt == C_HOLD_LAST);
  end

  // Next-state and next-output logic for the IDLE/GRANT controller
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold_cnt;
    w_gnt_nxt     = r_gnt;
    w_idx_nxt     = r_gnt_idx;
    w_preempt_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (en && w_found) begin
          w_gnt_nxt   = 8'b1 << w_win;
          w_idx_nxt   = w_win;
          w_hold_nxt  = 8'd0;
          w_state_nxt = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (w_release || w_timeout) begin
          // End of grant: advance the pointer and re-arbitrate in the same
          // edge so a waiting requester gets the resource with no idle gap.
          w_ptr_nxt     = r_gnt_idx + 3'd1;
          w_preempt_nxt = w_timeout;
          w_hold_nxt    = 8'd0;
          if (en && w_found) begin
            w_gnt_nxt   = 8'b1 << w_win;
            w_idx_nxt   = w_win;
            w_state_nxt = ST_GRANT;
          end else begin
            w_gnt_nxt   = 8'd0;
            w_state_nxt = ST_IDLE;
          end
        end else if (r_hold_cnt != C_HOLD_SAT) begin
          w_hold_nxt = r_hold_cnt + 8'd1;
        end
      end

      default: begin
        w_gnt_nxt   = 8'd0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Clear acts asynchronously and can interrupt
  // a grant.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 3'd0;
      r_hold_cnt <= 8'd0;
      r_gnt      <= 8'd0;
      r_gnt_idx  <= 3'd0;
      r_preempt  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_idx  <= w_idx_nxt;
      r_preempt  <= w_preempt_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = |r_gnt;
  assign preempt   = r_preempt;

endmodule
`default_nettype wire
